conv3d_rd_sched: RTL and testbench
==================================

// Module: conv3d_rd_sched
// PURPOSE
//  Read scheduler for the conv3d engine. Consumes the start/prefetch pulses and layer registers from the
//  config block and issues one-at-a-time burst read requests to the shared memory reader.
//  Sequences the weight prefetch and the per-output-row input (X) fetches, and arbitrates between them.
//  Reports busy/done to the layer controller.
// PARAMETERS
//  AW  30  byte-address width of all base/offset/request addresses
// PORTS
//  clk             in   1    clock
//  rst             in   1    asynchronous reset, active high
//  cfg_ena         in   1    1-cycle layer-start pulse
//  cfg_prefetch    in   1    1-cycle weight-prefetch pulse
//  cfg_xbase       in   AW   X row 0 address
//  cfg_xoffset     in   AW   X row stride
//  cfg_ybase       in   AW   Y row 0 address (CONV3D_SCHED_YREAD_EN only)
//  cfg_yoffset     in   AW   Y row stride (CONV3D_SCHED_YREAD_EN only)
//  cfg_height_out  in   9    number of output rows
//  cfg_length_in   in   18   X/Y burst length, words
//  cfg_waddr       in   AW   weight address
//  cfg_length_w    in   8    weight burst length, words
//  rd_req          out  1    request valid
//  rd_addr         out  AW   request address
//  rd_len          out  18   request length, words (weight length zero-extended)
//  rd_src          out  2    0=weight 1=X 2=Y
//  rd_ack          in   1    request accepted this cycle (rd_req&rd_ack)
//  rd_done         in   1    1-cycle pulse, accepted burst fully returned
//  busy            out  1    layer in progress
//  done            out  1    1-cycle pulse, last row burst done
//  cfg_drop        out  1    1-cycle pulse, cfg_ena ignored (already busy)
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, pending-prefetch flag 0, counters 0.
//  - Async reset mid-burst drops the request; no done is generated.
//  - cfg_ena in IDLE: snapshot all cfg_* into shadow registers. Row counter r=0, xaddr=xbase, yaddr=ybase.
//    busy=1 from the next cycle.
//  - cfg_ena while busy: ignored; cfg_drop pulses the next cycle.
//  - cfg_prefetch: sets wpend; its snapshot is waddr/length_w.
//  - A second cfg_prefetch before service overwrites the snapshot; one fetch only.
//  - FSM states: IDLE, WREQ, WWAIT, XREQ, XWAIT, YREQ, YWAIT, FIN.
//    - IDLE: wpend -> WREQ (priority over a same-cycle cfg_ena; the start is still latched -> busy).
//    - IDLE: else start -> XREQ.
//    - WREQ: rd_req=1, src=0. On ack: clear wpend -> WWAIT.
//    - WWAIT: on rd_done, return to XREQ if the layer is active and rows remain; else IDLE.
//    - XREQ: rd_req=1, addr=xaddr, src=1. On ack -> XWAIT.
//    - XWAIT: on rd_done, xaddr+=xoffset and r++. Then -> YREQ if YREAD_EN, else -> row-end.
//    - Row-end: r==height_out -> FIN; else wpend -> WREQ (prefetch only between rows); else XREQ.
//    - FIN: done=1 for 1 cycle, busy=0 -> IDLE.
//  - rd_req/rd_addr/rd_len/rd_src are registered and held stable while rd_req&!rd_ack.
//  - rd_req drops the cycle after ack.
//  - First rd_req asserts 2 cycles after cfg_ena (snapshot, then request).
//  - Address arithmetic wraps modulo 2^AW; no overflow flag.
//  - height_out==0: no X/Y requests; FIN the cycle after snapshot; done still pulses.
//  - rd_done outside a WAIT state is ignored.
//  - rd_ack without rd_req is ignored.
//  - Only one outstanding request at any time.
// CONFIGURATION
//  CONV3D_SCHED_YREAD_EN defined:
//    - After each X row: YREQ (addr=yaddr, len=length_in, src=2) then YWAIT.
//    - On its rd_done: yaddr+=yoffset, then row-end.
//  CONV3D_SCHED_YREAD_EN undefined:
//    - Y states and cfg_ybase/cfg_yoffset logic removed; ports kept, unused.
//    - rd_src never 2.
// TESTING
//  - Basic layer: xbase=0x1000, xoffset=0x200, height_out=3, length_in=64, ack/done immediate.
//    -> X reqs at 0x1000/0x1200/0x1400, len 64, then one done pulse.
//  - Prefetch priority: prefetch (waddr=0x80, len=16) and cfg_ena in the same cycle.
//    -> weight req src=0 len=16 first, then X rows.
//  - Prefetch mid-layer: prefetch during the row-1 burst, height_out=3.
//    -> weight req inserted after row 1 completes, before row 2.
//    -> done after row 3.
//  - Backpressure/boundaries:
//    - rd_ack held low 5 cycles -> rd_req/addr/len stable throughout.
//    - height_out=0 -> no reqs, done 2 cycles after cfg_ena.
//    - xbase=2^AW-0x100, xoffset=0x200 -> second addr 0x100 (wrap).
//  - Drop/reset: cfg_ena while busy -> cfg_drop pulse, row count unaffected.
//    rst mid-XWAIT -> all outputs 0, no done; a new cfg_ena restarts at row 0.
//  - YREAD_EN: ybase=0x8000, yoffset=0x40, height_out=2.
//    -> order X0 Y0(0x8000) X1 Y1(0x8040), then done.

Source files
------------

// File: rtl/conv3d_rd_sched.sv
// conv3d_rd_sched: read scheduler for the conv3d engine.
// Sequences the weight prefetch burst and the per-output-row X bursts,
// issuing one burst read request at a time to the shared memory reader.
// Optional feature: define CONV3D_SCHED_YREAD_EN to follow every X row with
// a Y-row burst (cfg_ybase/cfg_yoffset are ignored when it is undefined).
module conv3d_rd_sched #(
   parameter int AW = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_ena,
   input  logic          cfg_prefetch,
   input  logic [AW-1:0] cfg_xbase,
   input  logic [AW-1:0] cfg_xoffset,
   input  logic [AW-1:0] cfg_ybase,
   input  logic [AW-1:0] cfg_yoffset,
   input  logic [8:0]    cfg_height_out,
   input  logic [17:0]   cfg_length_in,
   input  logic [AW-1:0] cfg_waddr,
   input  logic [7:0]    cfg_length_w,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   output logic [17:0]   rd_len,
   output logic [1:0]    rd_src,
   input  logic          rd_ack,
   input  logic          rd_done,
   output logic          busy,
   output logic          done,
   output logic          cfg_drop
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WREQ  = 3'd1;
   localparam logic [2:0] S_WWAIT = 3'd2;
   localparam logic [2:0] S_XREQ  = 3'd3;
   localparam logic [2:0] S_XWAIT = 3'd4;
`ifdef CONV3D_SCHED_YREAD_EN
   localparam logic [2:0] S_YREQ  = 3'd5;
   localparam logic [2:0] S_YWAIT = 3'd6;
`endif
   localparam logic [2:0] S_FIN   = 3'd7;

   logic [2:0]    state;
   logic          wpend;
   logic [AW-1:0] w_addr_s;
   logic [7:0]    w_len_s;
   logic [AW-1:0] xaddr;
   logic [AW-1:0] xoffset_s;
   logic [17:0]   len_s;
   logic [8:0]    height_s;
   logic [8:0]    row;
   logic [8:0]    row_inc;
   logic          start_ok;
   logic          pf_any;
   logic [AW-1:0] w_addr_now;
   logic [7:0]    w_len_now;
   logic          w_accept;
   logic          row_end_ev;
   logic          row_last;

`ifdef CONV3D_SCHED_YREAD_EN
   logic [AW-1:0] yaddr;
   logic [AW-1:0] yoffset_s;
`else
   logic          unused_y;
   assign unused_y = ^{cfg_ybase, cfg_yoffset};
`endif

   // Decode start/prefetch conditions and the end-of-row event.
   // A prefetch pulse arriving this cycle counts as pending immediately so it
   // wins over a same-cycle layer start, and its address is forwarded.
   always_comb begin
      start_ok   = cfg_ena && !busy;
      pf_any     = wpend || cfg_prefetch;
      w_addr_now = cfg_prefetch ? cfg_waddr : w_addr_s;
      w_len_now  = cfg_prefetch ? cfg_length_w : w_len_s;
      w_accept   = (state == S_WREQ) && rd_req && rd_ack;
      row_inc    = row + 9'd1;
`ifdef CONV3D_SCHED_YREAD_EN
      row_end_ev = (state == S_YWAIT) && rd_done;
      row_last   = (row == height_s);
`else
      row_end_ev = (state == S_XWAIT) && rd_done;
      row_last   = (row_inc == height_s);
`endif
   end

   // Layer shadow registers, captured only when a start is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xoffset_s <= '0;
         len_s     <= '0;
         height_s  <= '0;
`ifdef CONV3D_SCHED_YREAD_EN
         yoffset_s <= '0;
`endif
      end else if (start_ok) begin
         xoffset_s <= cfg_xoffset;
         len_s     <= cfg_length_in;
         height_s  <= cfg_height_out;
`ifdef CONV3D_SCHED_YREAD_EN
         yoffset_s <= cfg_yoffset;
`endif
      end
   end

   // Pending weight prefetch; a newer pulse overwrites the snapshot and re-arms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wpend    <= 1'b0;
         w_addr_s <= '0;
         w_len_s  <= '0;
      end else if (cfg_prefetch) begin
         wpend    <= 1'b1;
         w_addr_s <= cfg_waddr;
         w_len_s  <= cfg_length_w;
      end else if (w_accept) begin
         wpend    <= 1'b0;
      end
   end

   // Flag a layer start that arrived while a layer was still running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_drop <= 1'b0;
      end else begin
         cfg_drop <= cfg_ena && busy;
      end
   end

   // Main sequencer: request issue/hold, row bookkeeping and layer completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_req  <= 1'b0;
         rd_addr <= '0;
         rd_len  <= '0;
         rd_src  <= 2'd0;
         xaddr   <= '0;
         row     <= '0;
`ifdef CONV3D_SCHED_YREAD_EN
         yaddr   <= '0;
`endif
      end else begin
         done <= 1'b0;

         if (start_ok) begin
            busy  <= 1'b1;
            row   <= '0;
            xaddr <= cfg_xbase;
`ifdef CONV3D_SCHED_YREAD_EN
            yaddr <= cfg_ybase;
`endif
         end

         case (state)
            S_IDLE: begin
               if (pf_any) begin
                  state <= S_WREQ;
               end else if (cfg_ena || busy) begin
                  state <= S_XREQ;
               end
            end

            S_WREQ: begin
               if (!rd_req) begin
                  rd_req  <= 1'b1;
                  rd_addr <= w_addr_now;
                  rd_len  <= {10'd0, w_len_now};
                  rd_src  <= 2'd0;
               end else if (rd_ack) begin
                  rd_req <= 1'b0;
                  state  <= S_WWAIT;
               end
            end

            S_WWAIT: begin
               if (rd_done) begin
                  state <= busy ? S_XREQ : S_IDLE;
               end
            end

            S_XREQ: begin
               if (!rd_req) begin
                  if (row == height_s) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     rd_req  <= 1'b1;
                     rd_addr <= xaddr;
                     rd_len  <= len_s;
                     rd_src  <= 2'd1;
                  end
               end else if (rd_ack) begin
                  rd_req <= 1'b0;
                  state  <= S_XWAIT;
               end
            end

            S_XWAIT: begin
               if (rd_done) begin
                  xaddr <= xaddr + xoffset_s;
                  row   <= row_inc;
`ifdef CONV3D_SCHED_YREAD_EN
                  state <= S_YREQ;
`endif
               end
            end

`ifdef CONV3D_SCHED_YREAD_EN
            S_YREQ: begin
               if (!rd_req) begin
                  rd_req  <= 1'b1;
                  rd_addr <= yaddr;
                  rd_len  <= len_s;
                  rd_src  <= 2'd2;
               end else if (rd_ack) begin
                  rd_req <= 1'b0;
                  state  <= S_YWAIT;
               end
            end

            S_YWAIT: begin
               if (rd_done) begin
                  yaddr <= yaddr + yoffset_s;
               end
            end
`endif

            S_FIN: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase

         if (row_end_ev) begin
            if (row_last) begin
               state <= S_FIN;
               done  <= 1'b1;
               busy  <= 1'b0;
            end else if (pf_any) begin
               state <= S_WREQ;
            end else begin
               state <= S_XREQ;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv3d_rd_sched.sv
// tb_conv3d_rd_sched: directed, table-driven bench for conv3d_rd_sched.
// Works for both the default build and CONV3D_SCHED_YREAD_EN builds.
module tb_conv3d_rd_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_ena;
   logic        cfg_prefetch;
   logic [29:0] cfg_xbase;
   logic [29:0] cfg_xoffset;
   logic [29:0] cfg_ybase;
   logic [29:0] cfg_yoffset;
   logic [8:0]  cfg_height_out;
   logic [17:0] cfg_length_in;
   logic [29:0] cfg_waddr;
   logic [7:0]  cfg_length_w;
   logic        rd_req;
   logic [29:0] rd_addr;
   logic [17:0] rd_len;
   logic [1:0]  rd_src;
   logic        rd_ack;
   logic        rd_done;
   logic        busy;
   logic        done;
   logic        cfg_drop;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [29:0]       xbase;
      logic [29:0]       xoffset;
      logic [8:0]        height;
      logic [17:0]       len;
      int                delay;
      int                nrows;
      logic [3:0][29:0]  addr;
   } vec_t;

   vec_t vecs[4];

   conv3d_rd_sched #(.AW(30)) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_ena        (cfg_ena),
      .cfg_prefetch   (cfg_prefetch),
      .cfg_xbase      (cfg_xbase),
      .cfg_xoffset    (cfg_xoffset),
      .cfg_ybase      (cfg_ybase),
      .cfg_yoffset    (cfg_yoffset),
      .cfg_height_out (cfg_height_out),
      .cfg_length_in  (cfg_length_in),
      .cfg_waddr      (cfg_waddr),
      .cfg_length_w   (cfg_length_w),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_len         (rd_len),
      .rd_src         (rd_src),
      .rd_ack         (rd_ack),
      .rd_done        (rd_done),
      .busy           (busy),
      .done           (done),
      .cfg_drop       (cfg_drop)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   // Hard time limit so a stuck design can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, required summary before it");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic setVec(input int idx, input logic [29:0] xb, input logic [29:0] xo,
                         input logic [8:0] h, input logic [17:0] len, input int dly, input int nr,
                         input logic [29:0] a0, input logic [29:0] a1,
                         input logic [29:0] a2, input logic [29:0] a3);
      vecs[idx].xbase   = xb;
      vecs[idx].xoffset = xo;
      vecs[idx].height  = h;
      vecs[idx].len     = len;
      vecs[idx].delay   = dly;
      vecs[idx].nrows   = nr;
      vecs[idx].addr[0] = a0;
      vecs[idx].addr[1] = a1;
      vecs[idx].addr[2] = a2;
      vecs[idx].addr[3] = a3;
   endtask

   // Loads a layer configuration and pulses cfg_ena (optionally cfg_prefetch) for one cycle.
   task automatic applyStimulus(input logic [29:0] xb, input logic [29:0] xo, input logic [8:0] h,
                                input logic [17:0] len, input bit pf,
                                input logic [29:0] wa, input logic [7:0] wl);
      cfg_xbase      = xb;
      cfg_xoffset    = xo;
      cfg_height_out = h;
      cfg_length_in  = len;
      cfg_waddr      = wa;
      cfg_length_w   = wl;
      cfg_ena        = 1'b1;
      cfg_prefetch   = pf;
      @(negedge clk);
      cfg_ena        = 1'b0;
      cfg_prefetch   = 1'b0;
   endtask

   // Waits for one request, checks it, holds off the ack for 'dly' cycles, then acks and completes it.
   task automatic serviceReq(input string name, input logic [29:0] ea, input logic [17:0] el,
                             input logic [1:0] es, input int dly, input bit pf);
      int n;
      bit stable;
      n = 0;
      while (rd_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (rd_req !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: rd_req=%0b, required 1 within 40 cycles", name, rd_req);
         return;
      end
      checkOutput({name, "_addr"}, 64'(rd_addr), 64'(ea));
      checkOutput({name, "_len"}, 64'(rd_len), 64'(el));
      checkOutput({name, "_src"}, 64'(rd_src), 64'(es));
      stable = 1'b1;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         if (rd_req !== 1'b1 || rd_addr !== ea || rd_len !== el || rd_src !== es) stable = 1'b0;
      end
      if (dly > 0) checkOutput({name, "_held"}, 64'(stable), 64'd1);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      checkOutput({name, "_reqdrop"}, 64'(rd_req), 64'd0);
      if (pf) begin
         cfg_prefetch = 1'b1;
         @(negedge clk);
         cfg_prefetch = 1'b0;
      end
      rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
   endtask

   // One output row: the X burst, followed by the Y burst when Y reads are built in.
   task automatic serviceRow(input logic [29:0] xa, input logic [17:0] len, input int row,
                             input int dly, input bit pf);
      serviceReq($sformatf("x%0d", row), xa, len, 2'd1, dly, pf);
`ifdef CONV3D_SCHED_YREAD_EN
      serviceReq($sformatf("y%0d", row), 30'h8000 + 30'(row) * 30'h40, len, 2'd2, dly, 1'b0);
`endif
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_done"}, 64'(done), 64'd1);
      @(negedge clk);
      checkOutput({name, "_done_pulse"}, 64'(done), 64'd0);
      checkOutput({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      bit quiet;
      int n;

      rst            = 1'b1;
      cfg_ena        = 1'b0;
      cfg_prefetch   = 1'b0;
      cfg_xbase      = '0;
      cfg_xoffset    = '0;
      cfg_ybase      = 30'h8000;
      cfg_yoffset    = 30'h40;
      cfg_height_out = '0;
      cfg_length_in  = '0;
      cfg_waddr      = '0;
      cfg_length_w   = '0;
      rd_ack         = 1'b0;
      rd_done        = 1'b0;

      setVec(0, 30'h1000,     30'h200, 9'd3, 18'd64,     0, 3, 30'h1000,     30'h1200, 30'h1400, 30'h0);
      setVec(1, 30'h3FFFFF00, 30'h200, 9'd2, 18'd5,      0, 2, 30'h3FFFFF00, 30'h100,  30'h0,    30'h0);
      setVec(2, 30'h0,        30'h10,  9'd4, 18'd1,      5, 4, 30'h0,        30'h10,   30'h20,   30'h30);
      setVec(3, 30'h2000,     30'h0,   9'd1, 18'h3FFFF,  0, 1, 30'h2000,     30'h0,    30'h0,    30'h0);

      repeat (2) @(negedge clk);
      checkOutput("rst_req",  64'(rd_req),   64'd0);
      checkOutput("rst_addr", 64'(rd_addr),  64'd0);
      checkOutput("rst_len",  64'(rd_len),   64'd0);
      checkOutput("rst_busy", 64'(busy),     64'd0);
      checkOutput("rst_done", 64'(done),     64'd0);
      checkOutput("rst_drop", 64'(cfg_drop), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven layers with immediate or delayed ack.
      for (int v = 0; v < 4; v++) begin
         $display("[TB] layer vector %0d", v);
         applyStimulus(vecs[v].xbase, vecs[v].xoffset, vecs[v].height, vecs[v].len, 1'b0, 30'h0, 8'd0);
         checkOutput($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
         checkOutput($sformatf("v%0d_noreq1", v), 64'(rd_req), 64'd0);
         @(negedge clk);
         checkOutput($sformatf("v%0d_req2", v), 64'(rd_req), 64'd1);
         for (int r = 0; r < vecs[v].nrows; r++) begin
            serviceRow(vecs[v].addr[r], vecs[v].len, r, vecs[v].delay, 1'b0);
         end
         waitDone($sformatf("v%0d", v));
      end

      // Prefetch and start in the same cycle: weight burst goes first.
      $display("[TB] prefetch priority");
      applyStimulus(30'h1000, 30'h200, 9'd2, 18'd64, 1'b1, 30'h80, 8'd16);
      checkOutput("pf_busy", 64'(busy), 64'd1);
      serviceReq("pf_w", 30'h80, 18'd16, 2'd0, 0, 1'b0);
      serviceRow(30'h1000, 18'd64, 0, 0, 1'b0);
      serviceRow(30'h1200, 18'd64, 1, 0, 1'b0);
      waitDone("pf");

      // Prefetch during row 1: weight burst between rows 1 and 2; cfg changes mid-layer are ignored.
      $display("[TB] prefetch mid-layer");
      applyStimulus(30'h1000, 30'h200, 9'd3, 18'd64, 1'b0, 30'h4440, 8'd8);
      cfg_xbase      = 30'h3333000;
      cfg_xoffset    = 30'h4;
      cfg_height_out = 9'd1;
      serviceRow(30'h1000, 18'd64, 0, 0, 1'b0);
      serviceRow(30'h1200, 18'd64, 1, 0, 1'b1);
      serviceReq("mid_w", 30'h4440, 18'd8, 2'd0, 0, 1'b0);
      serviceRow(30'h1400, 18'd64, 2, 0, 1'b0);
      waitDone("mid");

      // Zero rows: no requests, done two cycles after the start pulse.
      $display("[TB] zero height");
      applyStimulus(30'h7000, 30'h10, 9'd0, 18'd4, 1'b0, 30'h0, 8'd0);
      checkOutput("h0_done1", 64'(done), 64'd0);
      checkOutput("h0_req1", 64'(rd_req), 64'd0);
      @(negedge clk);
      checkOutput("h0_done2", 64'(done), 64'd1);
      checkOutput("h0_req2", 64'(rd_req), 64'd0);
      @(negedge clk);
      checkOutput("h0_done3", 64'(done), 64'd0);
      checkOutput("h0_idle", 64'(busy), 64'd0);

      // Start while busy is dropped and does not disturb the running layer.
      $display("[TB] start while busy");
      applyStimulus(30'h500, 30'h100, 9'd2, 18'd32, 1'b0, 30'h0, 8'd0);
      checkOutput("drop_before", 64'(cfg_drop), 64'd0);
      cfg_xbase      = 30'h9990000;
      cfg_height_out = 9'd5;
      cfg_ena        = 1'b1;
      @(negedge clk);
      cfg_ena        = 1'b0;
      checkOutput("drop_pulse", 64'(cfg_drop), 64'd1);
      @(negedge clk);
      checkOutput("drop_after", 64'(cfg_drop), 64'd0);
      serviceRow(30'h500, 18'd32, 0, 0, 1'b0);
      serviceRow(30'h600, 18'd32, 1, 0, 1'b0);
      waitDone("drop");

      // Reset in the middle of an X burst, then a fresh layer from row 0.
      $display("[TB] reset mid-burst");
      applyStimulus(30'h1000, 30'h200, 9'd3, 18'd64, 1'b0, 30'h0, 8'd0);
      n = 0;
      while (rd_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rstmid_addr", 64'(rd_addr), 64'h1000);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rstmid_req",  64'(rd_req),  64'd0);
      checkOutput("rstmid_a",    64'(rd_addr), 64'd0);
      checkOutput("rstmid_src",  64'(rd_src),  64'd0);
      checkOutput("rstmid_busy", 64'(busy),    64'd0);
      @(negedge clk);
      rst     = 1'b0;
      rd_done = 1'b1;
      rd_ack  = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
      rd_ack  = 1'b0;
      quiet   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (done !== 1'b0 || rd_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
         @(negedge clk);
      end
      checkOutput("rstmid_quiet", 64'(quiet), 64'd1);
      applyStimulus(30'h1000, 30'h200, 9'd3, 18'd64, 1'b0, 30'h0, 8'd0);
      serviceRow(30'h1000, 18'd64, 0, 0, 1'b0);
      serviceRow(30'h1200, 18'd64, 1, 0, 1'b0);
      serviceRow(30'h1400, 18'd64, 2, 0, 1'b0);
      waitDone("restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
